serial_add_sched: RTL and testbench
===================================

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand/sum width in bits.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (>=2).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  SHALL flag a pending add per requester.
REQ-006 req_ready  output  NREQ  SHALL be one-hot, or zero, and SHALL mark the accepted requester.
REQ-007 req_a, req_b  input  NREQ*WIDTH  SHALL carry the packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 rsp_valid/rsp_ready  output/input  1/1  SHALL form the result handshake.
REQ-009 rsp_sum  output  WIDTH, rsp_carry  output  1, rsp_id  output  clog2(NREQ), rsp_err  output  1  SHALL carry the result.
REQ-010 adder_load, adder_enable  output  1  SHALL drive the shared serial adder's load and enable pins.
REQ-011 adder_a, adder_b  output  WIDTH  SHALL drive the adder's operand inputs.
REQ-012 adder_sum  input  WIDTH, adder_carry  input  1, adder_done  input  1  SHALL be the adder's outputs.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN and RESP.
REQ-015 IDLE with any req_valid high SHALL:
- grant round-robin, searching upward from rr_ptr with wrap-around;
- assert req_ready[grant] combinationally for that cycle;
- capture the operands and the id;
- go to LOAD.
REQ-016 LOAD SHALL assert adder_load for exactly one cycle with the captured operands on adder_a/adder_b, then go to RUN.
REQ-017 RUN SHALL hold adder_enable high until adder_done is sampled high.
REQ-018 On that RUN cycle, the block SHALL capture adder_sum and adder_carry and go to RESP.
REQ-019 RESP SHALL hold rsp_valid high with stable rsp_sum, rsp_carry, rsp_id and rsp_err until rsp_ready is high.
REQ-020 On the RESP handshake, the block SHALL set rr_ptr = (grant+1) mod NREQ and return to IDLE.
REQ-021 Latency SHALL be WIDTH+3 cycles from the accept cycle to the first rsp_valid cycle (the IDLE-to-IDLE cycle count SHALL be WIDTH+4, plus any RESP stall).
REQ-022 req_ready SHALL be zero outside IDLE; no second request SHALL be accepted while a job is outstanding.
REQ-023 Requesters that drop req_valid before being granted SHALL be skipped without side effect.
REQ-024 adder_load and adder_enable SHALL never be high in the same cycle.
REQ-025 adder_a and adder_b SHALL hold the captured operands from LOAD through RESP.

Reset
REQ-026 With rst_n low, the block SHALL immediately force:
- state=IDLE and rr_ptr=0;
- req_ready=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, rsp_err=0;
- adder_load=0, adder_enable=0, adder_a=0, adder_b=0, busy=0.
REQ-027 Reset asserted mid-job (LOAD, RUN or RESP) SHALL discard the job with no response; the first post-reset grant SHALL go to the lowest valid index.

Configuration
REQ-028 With SERIAL_ADD_SCHED_TIMEOUT_EN defined, a watchdog SHALL count RUN cycles.
REQ-029 If adder_done is not seen within WIDTH+4 RUN cycles, the block SHALL enter RESP with rsp_err=1, rsp_sum=0 and rsp_carry=0.
REQ-030 Without SERIAL_ADD_SCHED_TIMEOUT_EN, no watchdog SHALL exist, rsp_err SHALL be tied to 0, and RUN SHALL wait indefinitely.

Structure
REQ-031 Package serial_add_pkg SHALL hold:
- the state enum;
- default WIDTH and NREQ constants;
- the timeout-margin constant (4).
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification (WIDTH=4, NREQ=4, adder model attached)
REQ-033 req_valid=0001, a=5, b=3 -> accept cycle 0; rsp_valid first in cycle 7; sum=8, carry=0, id=0.
REQ-034 req_valid=0100, a=15, b=1 -> sum=0, carry=1, id=2.
REQ-035 req_valid=1111 held through four jobs -> ids 0,1,2,3 in order; with 0101 after id 3 -> ids 0,2.
REQ-036 rsp_ready low for 5 cycles in RESP -> rsp fields stable, req_ready stays 0, busy=1; the handshake on the 6th cycle -> IDLE.
REQ-037 rst_n pulsed low in RUN -> all outputs 0 at once, no rsp_valid; the next req_valid=0010 -> id 1 granted.
REQ-038 With SERIAL_ADD_SCHED_TIMEOUT_EN and adder_done stuck at 0 -> rsp_valid after 8 RUN cycles with rsp_err=1 and rsp_sum=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg -- shared definitions for the serial-adder scheduler.
//   state_e         : scheduler FSM states (IDLE, LOAD, RUN, RESP)
//   DEF_WIDTH       : default operand/sum width
//   DEF_NREQ        : default number of requesters
//   TIMEOUT_MARGIN  : extra RUN cycles allowed beyond WIDTH before the
//                     watchdog (SERIAL_ADD_SCHED_TIMEOUT_EN) gives up
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_NREQ       = 4;
    localparam int TIMEOUT_MARGIN = 4;

endpackage

// File: rtl/serial_add_sched_if.sv
// serial_add_sched_if -- request/response bus of the serial-adder scheduler.
//   req_valid[NREQ]        : pending add per requester
//   req_ready[NREQ]        : one-hot accept strobe (zero when nothing accepted)
//   req_a/req_b[NREQ*WIDTH]: packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready    : result handshake
//   rsp_sum/rsp_carry/rsp_id/rsp_err : result payload
// Modports: master = requester side, slave = scheduler side.
interface serial_add_sched_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*WIDTH-1:0]    req_a;
    logic [NREQ*WIDTH-1:0]    req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;
    logic [$clog2(NREQ)-1:0]  rsp_id;
    logic                     rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id, rsp_err
    );
endinterface

// File: rtl/serial_add_sched_rr_arbiter.sv
// rr_arbiter -- combinational round-robin grant.
//   req[NREQ]   : request vector
//   ptr[ID_W]   : highest-priority index; search runs upward with wrap-around
//   grant[NREQ] : one-hot grant, zero when no request is pending
module rr_arbiter
    import serial_add_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant
);
    localparam int ID_W = $clog2(NREQ);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched -- shares one external serial adder among NREQ requesters.
// A round-robin winner is accepted in IDLE, its operands are loaded into the
// adder (LOAD), the adder is clocked until it reports done (RUN), and the
// result is held until the consumer takes it (RESP).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : request/response bus (serial_add_sched_if)
//   adder_load/enable   : adder control pins (never high together)
//   adder_a/adder_b     : captured operands, held from LOAD through RESP
//   adder_sum/carry/done: adder results
//   busy                : high in every state except IDLE
// Optional build macro: SERIAL_ADD_SCHED_TIMEOUT_EN adds a RUN-state watchdog
// that ends a job with rsp_err=1 after WIDTH+TIMEOUT_MARGIN RUN cycles.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_sched_if.slave bus,
    output logic              adder_load,
    output logic              adder_enable,
    output logic [WIDTH-1:0]  adder_a,
    output logic [WIDTH-1:0]  adder_b,
    input  logic [WIDTH-1:0]  adder_sum,
    input  logic              adder_carry,
    input  logic              adder_done,
    output logic              busy
);
    localparam int ID_W = $clog2(NREQ);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] LOAD = ST_LOAD;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_next;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant and pick that requester's operands.
    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
                sel_a     = bus.req_a[i*WIDTH +: WIDTH];
                sel_b     = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next pointer is one past the job just completed, wrapping at NREQ.
    assign rr_next = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;

`ifdef SERIAL_ADD_SCHED_TIMEOUT_EN
    localparam int WD_LAST = WIDTH + TIMEOUT_MARGIN - 1;
    localparam int WD_W    = $clog2(WIDTH + TIMEOUT_MARGIN);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            err_q;

    // Counts RUN cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state != RUN) begin
            wd_cnt <= '0;
        end else if (!wd_expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expired  = (wd_cnt == WD_W'(WD_LAST));
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADD_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        id_q  <= grant_idx;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (adder_done) begin
                        sum_q   <= adder_sum;
                        carry_q <= adder_carry;
`ifdef SERIAL_ADD_SCHED_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state   <= RESP;
                    end
`ifdef SERIAL_ADD_SCHED_TIMEOUT_EN
                    // A real completion on the last allowed cycle wins.
                    else if (wd_expired) begin
                        sum_q   <= '0;
                        carry_q <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All control outputs decode from state so reset clears them at once.
    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_id    = id_q;
    assign adder_load    = (state == LOAD);
    assign adder_enable  = (state == RUN);
    assign adder_a       = a_q;
    assign adder_b       = b_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched -- directed bench for serial_add_sched (WIDTH=4, NREQ=4)
// with a bit-serial adder model attached and a scoreboard of expected results.
module tb_serial_add_sched;
    import serial_add_pkg::*;

    localparam int W = 4;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_add_sched_if #(.WIDTH(W), .NREQ(N)) bus_if ();

    logic         adder_load, adder_enable, adder_carry, adder_done, busy;
    logic [W-1:0] adder_a, adder_b, adder_sum;

    serial_add_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .adder_load   (adder_load),
        .adder_enable (adder_enable),
        .adder_a      (adder_a),
        .adder_b      (adder_b),
        .adder_sum    (adder_sum),
        .adder_carry  (adder_carry),
        .adder_done   (adder_done),
        .busy         (busy)
    );

    // Bit-serial adder model: one bit per enabled cycle, done after W bits.
    logic [W-1:0] m_a = '0, m_b = '0, m_s = '0;
    logic         m_c = 1'b0;
    logic [2:0]   m_cnt = '0;
    logic         stuck = 1'b0;
    logic [1:0]   bi;
    logic         fa_s, fa_co;

    assign bi    = m_cnt[1:0];
    assign fa_s  = m_a[bi] ^ m_b[bi] ^ m_c;
    assign fa_co = (m_a[bi] & m_b[bi]) | (m_c & (m_a[bi] ^ m_b[bi]));

    always @(posedge clk) begin
        if (adder_load) begin
            m_a   <= adder_a;
            m_b   <= adder_b;
            m_s   <= '0;
            m_c   <= 1'b0;
            m_cnt <= '0;
        end else if (adder_enable && (m_cnt < 3'(W))) begin
            m_s[bi] <= fa_s;
            m_c     <= fa_co;
            m_cnt   <= m_cnt + 3'd1;
        end
    end

    assign adder_done  = (m_cnt == 3'(W)) && !stuck;
    assign adder_sum   = m_s;
    assign adder_carry = m_c;

    typedef struct {
        logic [3:0] sum;
        logic       carry;
        logic [1:0] id;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   ids[$];
    int   checks = 0;
    int   failures = 0;

    logic       m_busy = 1'b0;
    int         m_ptr = 0;
    int         cycle = 0;
    int         acc_cyc = 0;
    int         exp_lat = W + 3;
    logic       expect_to = 1'b0;
    logic       rsp_seen = 1'b0;
    logic       accepted = 1'b0;
    int         rsp_cnt = 0;
    logic [3:0] exp_a = '0, exp_b = '0;

    logic       samp_valid = 1'b0, samp_carry = 1'b0, samp_err = 1'b0;
    logic       samp_busy = 1'b0, samp_enable = 1'b0;
    logic [3:0] samp_sum = '0, samp_rdy = '0;
    logic [1:0] samp_id = '0;
    logic [3:0] hs_sum = '0;
    logic       hs_carry = 1'b0, hs_err = 1'b0;
    logic [1:0] hs_id = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rr_model(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int ix = (p + k) % 4;
            if (v[ix]) return 4'b0001 << ix;
        end
        return 4'b0000;
    endfunction

    // Per-cycle observer: grant model, hold checks, scoreboard push/pop.
    task automatic monitor();
        logic [3:0] eg;
        logic [4:0] full;
        exp_t       e;
        int         gi;
        cycle++;
        eg = m_busy ? 4'b0000 : rr_model(bus_if.req_valid, m_ptr);
        chk("req_ready", bus_if.req_ready, eg);
        chk("busy", busy, m_busy);
        chk("load_enable_excl", adder_load & adder_enable, 0);
        if (m_busy) begin
            chk("adder_a_hold", adder_a, exp_a);
            chk("adder_b_hold", adder_b, exp_b);
        end
        if (bus_if.rsp_valid && !m_busy) chk("unexpected_rsp_valid", 1, 0);
        if (bus_if.rsp_valid && m_busy && !rsp_seen) begin
            chk("latency", cycle - acc_cyc, exp_lat);
            rsp_seen = 1'b1;
        end
        samp_valid  = bus_if.rsp_valid;
        samp_sum    = bus_if.rsp_sum;
        samp_carry  = bus_if.rsp_carry;
        samp_id     = bus_if.rsp_id;
        samp_err    = bus_if.rsp_err;
        samp_rdy    = bus_if.req_ready;
        samp_busy   = busy;
        samp_enable = adder_enable;
        if (eg != 4'b0000) begin
            gi = 0;
            for (int k = 0; k < 4; k++) if (eg[k]) gi = k;
            exp_a = bus_if.req_a[gi*4 +: 4];
            exp_b = bus_if.req_b[gi*4 +: 4];
            full  = {1'b0, exp_a} + {1'b0, exp_b};
            e.id  = 2'(gi);
            e.err = expect_to;
            e.sum   = expect_to ? 4'd0 : full[3:0];
            e.carry = expect_to ? 1'b0 : full[4];
            sb.push_back(e);
            m_busy   = 1'b1;
            acc_cyc  = cycle;
            rsp_seen = 1'b0;
            accepted = 1'b1;
        end else if (bus_if.rsp_valid && bus_if.rsp_ready && m_busy) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_sum", bus_if.rsp_sum, e.sum);
                chk("rsp_carry", bus_if.rsp_carry, e.carry);
                chk("rsp_id", bus_if.rsp_id, e.id);
                chk("rsp_err", bus_if.rsp_err, e.err);
                m_ptr = (int'(e.id) + 1) % 4;
            end
            hs_sum   = bus_if.rsp_sum;
            hs_carry = bus_if.rsp_carry;
            hs_id    = bus_if.rsp_id;
            hs_err   = bus_if.rsp_err;
            ids.push_back(int'(bus_if.rsp_id));
            m_busy = 1'b0;
            rsp_cnt++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b);
        bus_if.req_valid = v;
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) cyc();
        if (!accepted) chk("accept_wait", 0, 1);
        bus_if.req_valid = '0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 200 && rsp_cnt < target; i++) cyc();
        if (rsp_cnt < target) chk("rsp_wait", rsp_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus_if.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus_if.rsp_valid, 0);
        chk({tag, "_rsp_sum"}, bus_if.rsp_sum, 0);
        chk({tag, "_rsp_carry"}, bus_if.rsp_carry, 0);
        chk({tag, "_rsp_id"}, bus_if.rsp_id, 0);
        chk({tag, "_rsp_err"}, bus_if.rsp_err, 0);
        chk({tag, "_adder_load"}, adder_load, 0);
        chk({tag, "_adder_enable"}, adder_enable, 0);
        chk({tag, "_adder_a"}, adder_a, 0);
        chk({tag, "_adder_b"}, adder_b, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int         exp_ids[6] = '{0, 1, 2, 3, 0, 2};
        logic [3:0] s_sum;
        logic       s_carry;
        logic [1:0] s_id;

        bus_if.req_valid = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single job, requester 0: 5+3
        send_req(4'b0001, 16'h0005, 16'h0003);
        wait_rsp(1);
        chk("t1_sum", hs_sum, 8);
        chk("t1_carry", hs_carry, 0);
        chk("t1_id", hs_id, 0);

        // Requester 2: 15+1 overflows into carry
        send_req(4'b0100, 16'h0F00, 16'h0100);
        wait_rsp(2);
        chk("t2_sum", hs_sum, 0);
        chk("t2_carry", hs_carry, 1);
        chk("t2_id", hs_id, 2);

        // Requester 3 wraps the pointer back to 0
        send_req(4'b1000, 16'h9000, 16'h6000);
        wait_rsp(3);
        chk("t3_id", hs_id, 3);

        // All four held: strict rotation, then 0101
        ids.delete();
        bus_if.req_valid = 4'b1111;
        for (int i = 0; i < 200 && rsp_cnt < 7; i++) begin
            cyc();
            bus_if.req_a = 16'($urandom);
            bus_if.req_b = 16'($urandom);
        end
        bus_if.req_valid = 4'b0101;
        wait_rsp(9);
        bus_if.req_valid = '0;
        chk("rr_count", ids.size(), 6);
        for (int i = 0; i < 6 && i < ids.size(); i++) chk("rr_order", ids[i], exp_ids[i]);

        // Response stall: 5 cycles of rsp_ready low, handshake on the 6th
        bus_if.rsp_ready = 1'b0;
        send_req(4'b0001, 16'h0007, 16'h0006);
        bus_if.req_valid = 4'b1000;
        for (int i = 0; i < 40 && !samp_valid; i++) cyc();
        chk("stall_resp_reached", samp_valid, 1);
        s_sum   = samp_sum;
        s_carry = samp_carry;
        s_id    = samp_id;
        chk("stall_first_sum", s_sum, 13);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_valid", samp_valid, 1);
            chk("stall_sum", samp_sum, s_sum);
            chk("stall_carry", samp_carry, s_carry);
            chk("stall_id", samp_id, s_id);
            chk("stall_err", samp_err, 0);
            chk("stall_req_ready", samp_rdy, 0);
            chk("stall_busy", samp_busy, 1);
        end
        bus_if.rsp_ready = 1'b1;
        cyc();
        chk("stall_handshake", rsp_cnt, 10);
        cyc();
        chk("stall_back_idle_rdy", samp_rdy, 4'b1000);
        bus_if.req_valid = '0;
        wait_rsp(11);
        chk("stall_next_id", hs_id, 3);

        // Move the pointer to 2, then reset in the middle of a RUN
        send_req(4'b0010, 16'h0030, 16'h0040);
        wait_rsp(12);
        send_req(4'b0100, 16'h0200, 16'h0300);
        for (int i = 0; i < 20 && !samp_enable; i++) cyc();
        chk("reset_in_run", samp_enable, 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        sb.delete();
        m_busy = 1'b0;
        m_ptr  = 0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        chk("midrst_no_rsp", rsp_cnt, 12);
        send_req(4'b1010, 16'h00A0, 16'h0050);
        wait_rsp(13);
        chk("post_rst_id", hs_id, 1);
        chk("post_rst_sum", hs_sum, 15);

`ifdef SERIAL_ADD_SCHED_TIMEOUT_EN
        // Adder never finishes: watchdog ends the job with an error
        stuck     = 1'b1;
        expect_to = 1'b1;
        exp_lat   = W + 6;
        send_req(4'b0001, 16'h0003, 16'h0002);
        wait_rsp(14);
        chk("to_err", hs_err, 1);
        chk("to_sum", hs_sum, 0);
        chk("to_carry", hs_carry, 0);
        stuck     = 1'b0;
        expect_to = 1'b0;
        exp_lat   = W + 3;
`endif

        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
